// File: rtl/wager_control.sv
// ---------------------------------------------------------------------------
// wager_control
//
// Bet-entry stage placed in front of the money-management block. The player
// dials a wager with up/down buttons (with auto-repeat while a button is
// held). The wager is clamped to the money available. On confirm, the block
// snapshots money-in-hand and holds wager_o/mih_o stable for the whole round.
//
// Ports:
//   clock      in   1   system clock, rising edge
//   reset_c    in   1   asynchronous, active-high reset
//   money_r    in  16   current money reported by money management
//   game_s     in   2   phase: 00 bet, 01 poker judge, 10 double-up, 11 hi-lo
//   bet_up     in   1   up button level (held = 1)
//   bet_down   in   1   down button level
//   bet_ok     in   1   confirm button level
//   wager_o    out 16   current / locked wager
//   mih_o      out 16   money-in-hand captured at confirm
//   bet_c      out  1   one-cycle pulse when a bet is accepted
//   game_over  out  1   sticky bankruptcy flag (cleared only by reset)
//   state_dbg  out  3   FSM state, for observation only
//
// Handshake: there is no valid/ready pair. bet_c is a single-cycle strobe
// that qualifies wager_o/mih_o. Both values then stay constant until the
// block returns to the betting phase.
// ---------------------------------------------------------------------------
module wager_control #(
  parameter logic [15:0] STEP       = 16'd10,
  parameter logic [15:0] MIN_BET    = 16'd10,
  parameter logic [15:0] MAX_BET    = 16'd1000,
  parameter int          REPEAT_DLY = 8,
  parameter int          REPEAT_INT = 4
) (
  input  logic        clock,
  input  logic        reset_c,
  input  logic [15:0] money_r,
  input  logic [1:0]  game_s,
  input  logic        bet_up,
  input  logic        bet_down,
  input  logic        bet_ok,
  output logic [15:0] wager_o,
  output logic [15:0] mih_o,
  output logic        bet_c,
  output logic        game_over,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTRY  = 3'd1,
    LOCKED = 3'd2,
    PLAY   = 3'd3,
    BROKE  = 3'd4
  } state_t;

  localparam int CW = $clog2(REPEAT_DLY + REPEAT_INT + 1);
  localparam logic [CW-1:0] DLY_C    = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] DLY_INT_C = CW'(REPEAT_DLY + REPEAT_INT);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  state_t        state, next_state;
  logic          up_q, down_q, ok_q;
  logic [CW-1:0] rep_cnt, rep_cnt_n, rep_inc;

  logic [15:0] wager_n, mih_n;
  logic        bet_c_n, game_over_n;

  // Exactly one of up/down held; both together cancel each other.
  logic up_only, down_only, single;
  logic up_press, down_press, ok_press, any_step_press;
  logic rep_fire, up_step, down_step;

  logic [15:0] cap;
  logic [16:0] up_sum, dn_thr;
  logic [15:0] up_val, dn_val, stepped, entry_val;

  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Press detection and auto-repeat
  // -------------------------------------------------------------------------
  always_comb begin
    up_only        = bet_up & ~bet_down;
    down_only      = bet_down & ~bet_up;
    single         = up_only | down_only;
    up_press       = up_only & ~up_q;
    down_press     = down_only & ~down_q;
    ok_press       = bet_ok & ~ok_q;
    any_step_press = up_press | down_press;

    // The counter value after this edge is the number of consecutive held
    // cycles. The first repeat fires at REPEAT_DLY. After that, the counter
    // folds back to REPEAT_DLY every REPEAT_INT cycles, so it stays bounded.
    rep_inc   = rep_cnt + ONE_C;
    rep_fire  = 1'b0;
    rep_cnt_n = '0;
    if (state == ENTRY && single) begin
      if (any_step_press) begin
        rep_cnt_n = ONE_C;
      end else if (rep_inc == DLY_C || rep_inc == DLY_INT_C) begin
        rep_cnt_n = DLY_C;
        rep_fire  = 1'b1;
      end else begin
        rep_cnt_n = rep_inc;
      end
    end

    up_step   = up_only & (up_press | rep_fire);
    down_step = down_only & (down_press | rep_fire);
  end

  // -------------------------------------------------------------------------
  // Wager arithmetic (17-bit intermediates so nothing wraps)
  // -------------------------------------------------------------------------
  always_comb begin
    cap    = (money_r < MAX_BET) ? money_r : MAX_BET;
    up_sum = {1'b0, wager_o} + {1'b0, STEP};
    up_val = (up_sum > {1'b0, cap}) ? cap : up_sum[15:0];
    dn_thr = {1'b0, MIN_BET} + {1'b0, STEP};
    dn_val = ({1'b0, wager_o} < dn_thr) ? MIN_BET : (wager_o - STEP);

    if (up_step)        stepped = up_val;
    else if (down_step) stepped = dn_val;
    else                stepped = wager_o;

    // The cap can move under us while in ENTRY, so clamp on every cycle.
    entry_val = (stepped > cap) ? cap : stepped;
  end

  // -------------------------------------------------------------------------
  // FSM next-state and registered-output next values
  // -------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    wager_n     = wager_o;
    mih_n       = mih_o;
    bet_c_n     = 1'b0;
    game_over_n = game_over;

    case (state)
      IDLE: begin
        if (game_s == 2'b00) begin
          if (money_r >= MIN_BET) begin
            next_state = ENTRY;
            wager_n    = MIN_BET;
          end else begin
            next_state  = BROKE;
            wager_n     = 16'd0;
            game_over_n = 1'b1;
          end
        end
      end
      ENTRY: begin
        if (ok_press) begin
          // Confirm takes priority; any step in the same cycle is dropped.
          next_state = LOCKED;
          mih_n      = money_r;
          bet_c_n    = 1'b1;
        end else begin
          wager_n = entry_val;
        end
      end
      LOCKED: begin
        if (game_s != 2'b00) next_state = PLAY;
      end
      PLAY: begin
        if (game_s == 2'b00) next_state = IDLE;
      end
      BROKE: begin
        wager_n     = 16'd0;
        game_over_n = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      state     <= IDLE;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      ok_q      <= 1'b0;
      rep_cnt   <= '0;
      wager_o   <= 16'd0;
      mih_o     <= 16'd1000;
      bet_c     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= next_state;
      up_q      <= bet_up;
      down_q    <= bet_down;
      ok_q      <= bet_ok;
      rep_cnt   <= rep_cnt_n;
      wager_o   <= wager_n;
      mih_o     <= mih_n;
      bet_c     <= bet_c_n;
      game_over <= game_over_n;
    end
  end

endmodule

// File: tb/tb_wager_control.sv
module tb_wager_control;

  logic        clock;
  logic        reset_c;
  logic [15:0] money_r;
  logic [1:0]  game_s;
  logic        bet_up, bet_down, bet_ok;
  logic [15:0] wager_o, mih_o;
  logic        bet_c, game_over;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  wager_control dut (
    .clock     (clock),
    .reset_c   (reset_c),
    .money_r   (money_r),
    .game_s    (game_s),
    .bet_up    (bet_up),
    .bet_down  (bet_down),
    .bet_ok    (bet_ok),
    .wager_o   (wager_o),
    .mih_o     (mih_o),
    .bet_c     (bet_c),
    .game_over (game_over),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] money;
    logic [1:0]  gs;
    logic        up;
    logic        dn;
    logic        ok;
    logic [15:0] w;
    logic [15:0] mih;
    logic        bc;
    logic        go;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [15:0] money, input logic [1:0] gs,
                              input logic up, input logic dn, input logic ok,
                              input logic [15:0] w, input logic [15:0] mih,
                              input logic bc, input logic go);
    vec_t v;
    v.money = money; v.gs = gs; v.up = up; v.dn = dn; v.ok = ok;
    v.w = w; v.mih = mih; v.bc = bc; v.go = go;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [15:0] w, input logic [15:0] mih,
                           input logic bc, input logic go);
    check("wager_o", idx, wager_o, w);
    check("mih_o", idx, mih_o, mih);
    check("bet_c", idx, {15'd0, bet_c}, {15'd0, bc});
    check("game_over", idx, {15'd0, game_over}, {15'd0, go});
  endtask

  task automatic drive(input logic [15:0] money, input logic [1:0] gs,
                       input logic up, input logic dn, input logic ok);
    money_r = money; game_s = gs; bet_up = up; bet_down = dn; bet_ok = ok;
  endtask

  initial begin
    int steps;
    logic [15:0] exp_w;

    // ---------------- vector table ----------------
    add(1000, 2'b01, 0, 0, 0,   0, 1000, 0, 0);  // IDLE, not betting phase
    add(1000, 2'b00, 0, 0, 0,  10, 1000, 0, 0);  // enter ENTRY at MIN_BET
    add(  25, 2'b00, 0, 0, 0,  10, 1000, 0, 0);
    add(  25, 2'b00, 1, 0, 0,  20, 1000, 0, 0);  // up
    add(  25, 2'b00, 0, 0, 0,  20, 1000, 0, 0);
    add(  25, 2'b00, 1, 0, 0,  25, 1000, 0, 0);  // clamped to money
    add(  25, 2'b00, 0, 0, 0,  25, 1000, 0, 0);
    add(  25, 2'b00, 1, 0, 0,  25, 1000, 0, 0);  // stays clamped
    add(  25, 2'b00, 0, 0, 0,  25, 1000, 0, 0);
    add(  25, 2'b00, 0, 1, 0,  15, 1000, 0, 0);  // down
    add(  25, 2'b00, 0, 0, 0,  15, 1000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(25, 2'b00, 0, 1, 0, 10, 1000, 0, 0);   // floor at MIN_BET
      add(25, 2'b00, 0, 0, 0, 10, 1000, 0, 0);
    end
    add(1000, 2'b00, 1, 0, 0,  20, 1000, 0, 0);
    add(1000, 2'b00, 0, 0, 0,  20, 1000, 0, 0);
    add(1000, 2'b00, 1, 1, 0,  20, 1000, 0, 0);  // up+down cancel
    add(1000, 2'b00, 0, 0, 0,  20, 1000, 0, 0);
    add(1000, 2'b00, 0, 1, 0,  10, 1000, 0, 0);
    add(1000, 2'b00, 0, 0, 0,  10, 1000, 0, 0);
    // Hold up for 20 cycles: press step at cycle 1, repeats at 8,12,16,20.
    steps = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1 || k == 8 || k == 12 || k == 16 || k == 20) steps++;
      exp_w = 16'(10 + 10 * steps);
      add(1000, 2'b00, 1, 0, 0, exp_w, 1000, 0, 0);
    end
    for (int i = 0; i < 3; i++) add(1000, 2'b00, 0, 0, 0, 60, 1000, 0, 0);
    add(1000, 2'b00, 0, 1, 0,  50, 1000, 0, 0);
    add(1000, 2'b00, 0, 0, 0,  50, 1000, 0, 0);
    add( 700, 2'b00, 0, 0, 1,  50,  700, 1, 0);  // confirm
    add( 700, 2'b00, 0, 0, 1,  50,  700, 0, 0);  // pulse is one cycle only
    add( 700, 2'b01, 1, 0, 0,  50,  700, 0, 0);  // -> PLAY, press ignored
    add( 700, 2'b01, 0, 0, 0,  50,  700, 0, 0);
    add( 700, 2'b11, 1, 0, 0,  50,  700, 0, 0);
    add( 700, 2'b11, 0, 0, 0,  50,  700, 0, 0);
    add( 700, 2'b00, 1, 0, 0,  50,  700, 0, 0);  // -> IDLE
    add( 700, 2'b00, 0, 0, 0,  10,  700, 0, 0);  // new round
    add( 700, 2'b00, 1, 0, 0,  20,  700, 0, 0);
    add( 700, 2'b00, 0, 0, 0,  20,  700, 0, 0);
    add( 700, 2'b00, 1, 0, 0,  30,  700, 0, 0);
    add( 700, 2'b00, 0, 0, 0,  30,  700, 0, 0);
    add( 700, 2'b00, 1, 0, 1,  30,  700, 1, 0);  // ok wins over up
    add( 700, 2'b01, 0, 0, 0,  30,  700, 0, 0);  // -> PLAY
    add(   5, 2'b00, 0, 0, 0,  30,  700, 0, 0);  // -> IDLE
    add(   5, 2'b00, 0, 0, 0,   0,  700, 0, 1);  // -> BROKE
    add(   5, 2'b00, 1, 0, 0,   0,  700, 0, 1);
    add(1000, 2'b00, 0, 0, 0,   0,  700, 0, 1);  // sticky
    add(1000, 2'b00, 0, 0, 1,   0,  700, 0, 1);  // ok ignored

    // ---------------- reset ----------------
    drive(1000, 2'b01, 0, 0, 0);
    reset_c = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all(-1, 0, 1000, 0, 0);
    @(negedge clock);
    reset_c = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].money, vecs[i].gs, vecs[i].up, vecs[i].dn, vecs[i].ok);
      @(posedge clock);
      #1;
      check_all(i, vecs[i].w, vecs[i].mih, vecs[i].bc, vecs[i].go);
    end

    // ---------------- reset out of BROKE, asynchronous ----------------
    @(negedge clock);
    reset_c = 1'b1;
    #1;
    check_all(1000, 0, 1000, 0, 0);
    @(negedge clock);
    reset_c = 1'b0;

    // ---------------- reset pulsed while LOCKED, before next edge ----------------
    drive(1000, 2'b00, 0, 0, 0);
    @(posedge clock); #1;
    check_all(1001, 10, 1000, 0, 0);
    @(negedge clock);
    drive(800, 2'b00, 0, 0, 1);
    @(posedge clock); #1;
    check_all(1002, 10, 800, 1, 0);
    #2;
    reset_c = 1'b1;
    #1;
    check_all(1003, 0, 1000, 0, 0);
    @(negedge clock);
    reset_c = 1'b0;
    drive(1000, 2'b01, 0, 0, 0);
    @(posedge clock); #1;
    check_all(1004, 0, 1000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: run did not reach its end, expected completion");
    $fatal(1);
  end

endmodule
